uart_tx_engine: RTL and testbench

- Parametrised UART transmit engine: serialises characters of configurable size with configurable parity and stop length.
- Adds a valid/ready input with a one-entry holding register for gap-free back-to-back frames, 1.5 stop bits, mark/space parity and break generation.
- Sits between the register/Wishbone layer and the uart_tx pin, alongside the receive frontend, driven by the same fractional baud increment.

---
 rtl/uart_tx_engine.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-entry holding register feeding a fractional-baud
// serialiser with configurable character size, parity, stop length and break.
module uart_tx_engine #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int MIN_DATA_WIDTH = 5,
  parameter int ACC_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ACC_WIDTH-1:0]      cr_acc_incr_i,
  input  logic [3:0]                cr_ds_i,
  input  logic [2:0]                cr_p_i,
  input  logic [1:0]                cr_s_i,
  input  logic                      valid_i,
  input  logic [MAX_DATA_WIDTH-1:0] data_i,
  output logic                      ready_o,
  input  logic                      break_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      uart_tx_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic [3:0] clamp_ds(input logic [3:0] ds);
    if (ds < 4'(MIN_DATA_WIDTH)) clamp_ds = 4'(MIN_DATA_WIDTH);
    else if (ds > 4'(MAX_DATA_WIDTH)) clamp_ds = 4'(MAX_DATA_WIDTH);
    else clamp_ds = ds;
  endfunction

  function automatic logic par_en(input logic [2:0] p);
    par_en = (p >= 3'b010) && (p <= 3'b101);
  endfunction

  // Stop length expressed in half-bit ticks.
  function automatic logic [3:0] stop_halves(input logic [1:0] s);
    case (s)
      2'b00:   stop_halves = 4'd2;
      2'b01:   stop_halves = 4'd3;
      default: stop_halves = 4'd4;
    endcase
  endfunction

  function automatic logic par_bit(input logic [2:0] p, input logic acc);
    case (p)
      3'b100:  par_bit = 1'b0;
      3'b101:  par_bit = 1'b1;
      default: par_bit = acc;
    endcase
  endfunction

  state_t                    r_state, w_state_d;
  logic [ACC_WIDTH-1:0]      r_acc, w_acc_d;
  logic [MAX_DATA_WIDTH-1:0] r_hold, r_shift, w_shift_d;
  logic                      r_hold_full, w_hold_full_d;
  logic [3:0]                r_cnt, w_cnt_d;
  logic                      r_par, w_par_d;
  logic [2:0]                r_p, w_p_d;
  logic [1:0]                r_s, w_s_d;
  logic                      r_tx, r_done, r_busy, r_ready;
  logic                      w_load, w_done_d, w_busy_d, w_line;
  logic [ACC_WIDTH:0]        w_sum;
  logic                      w_tick, w_half, w_accept;

  assign w_sum    = {1'b0, r_acc} + {1'b0, cr_acc_incr_i};
  assign w_tick   = w_sum[ACC_WIDTH];
  assign w_half   = w_tick | (~r_acc[ACC_WIDTH-1] & w_sum[ACC_WIDTH-1]);
  assign w_accept = valid_i & r_ready;

  // Next-state, datapath and holding-register control.
  always_comb begin
    w_state_d = r_state;
    w_acc_d   = w_sum[ACC_WIDTH-1:0];
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    w_par_d   = r_par;
    w_p_d     = r_p;
    w_s_d     = r_s;
    w_load    = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (break_i) begin
          w_state_d = S_BREAK;
        end else if (r_hold_full) begin
          w_load    = 1'b1;
          w_state_d = S_START;
          w_acc_d   = '0;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) w_state_d = S_DATA;
        else w_state_d = S_START;
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_d = {1'b0, r_shift[MAX_DATA_WIDTH-1:1]};
          w_par_d   = r_par ^ r_shift[0];
          if (r_cnt == 4'd1) begin
            if (par_en(r_p)) w_state_d = S_PARITY;
            else w_state_d = S_STOP;
            w_cnt_d = stop_halves(r_s);
          end else begin
            w_cnt_d = r_cnt - 4'd1;
          end
        end else begin
          w_state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_d = S_STOP;
          w_cnt_d   = stop_halves(r_s);
        end else begin
          w_state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_half) begin
          if (r_cnt == 4'd1) begin
            w_done_d = 1'b1;
            if (r_hold_full && !break_i) begin
              w_load    = 1'b1;
              w_state_d = S_START;
              // Ending on a mid-bit half-tick: re-phase so the start bit is a full bit.
              if (!w_tick) w_acc_d[ACC_WIDTH-1] = 1'b0;
              else w_acc_d = w_sum[ACC_WIDTH-1:0];
            end else begin
              w_state_d = S_IDLE;
            end
          end else begin
            w_cnt_d = r_cnt - 4'd1;
          end
        end else begin
          w_state_d = S_STOP;
        end
      end
      S_BREAK: begin
        if (w_tick && !break_i) w_state_d = S_IDLE;
        else w_state_d = S_BREAK;
      end
      default: w_state_d = S_IDLE;
    endcase

    if (w_load) begin
      w_shift_d     = r_hold;
      w_cnt_d       = clamp_ds(cr_ds_i);
      w_par_d       = (cr_p_i == 3'b011);
      w_p_d         = cr_p_i;
      w_s_d         = cr_s_i;
      w_hold_full_d = 1'b0;
    end else begin
      w_hold_full_d = r_hold_full | valid_i;
    end
    w_busy_d = (w_state_d != S_IDLE) | w_hold_full_d;
  end

  // Serial line level for the current state.
  always_comb begin
    case (r_state)
      S_IDLE:   w_line = 1'b1;
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
      S_PARITY: w_line = par_bit(r_p, r_par);
      S_STOP:   w_line = 1'b1;
      S_BREAK:  w_line = 1'b0;
      default:  w_line = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= 4'd0;
      r_par       <= 1'b0;
      r_p         <= 3'b000;
      r_s         <= 2'b00;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_shift     <= w_shift_d;
      r_cnt       <= w_cnt_d;
      r_par       <= w_par_d;
      r_p         <= w_p_d;
      r_s         <= w_s_d;
      r_hold_full <= w_hold_full_d;
      r_ready     <= ~w_hold_full_d;
      r_tx        <= w_line;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
      if (w_accept) r_hold <= data_i;
    end
  end

  assign ready_o   = r_ready;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign uart_tx_o = r_tx;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames are queued when a
// character is accepted and compared against the decoded serial line.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] incr;
  logic [3:0]  ds;
  logic [2:0]  par;
  logic [1:0]  stp;
  logic        valid;
  logic [8:0]  data;
  logic        ready, brk, busy, done, tx;

  uart_tx_engine #(.MAX_DATA_WIDTH(9), .MIN_DATA_WIDTH(5), .ACC_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .cr_acc_incr_i(incr), .cr_ds_i(ds), .cr_p_i(par),
    .cr_s_i(stp), .valid_i(valid), .data_i(data), .ready_o(ready), .break_i(brk),
    .busy_o(busy), .done_o(done), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          cpb;
    int          frame_clk;
    bit          chained;
  } exp_t;

  exp_t sb[$];
  int   cpb = 2;
  bit   mon_en = 1'b1;
  int   last_start = 0;
  int   prev_clk = 0;
  int   acc_cyc = 0;
  int   n_done = 0;
  int   last_done_cyc = 0;
  int   n_rdy_fall = 0;
  bit   rdy_prev = 1'b0;

  function automatic int eff_ds(input logic [3:0] d);
    if (d < 4'd5) return 5;
    if (d > 4'd9) return 9;
    return int'(d);
  endfunction

  // Reference frame: start, data LSB first, optional parity, first stop bit.
  function automatic exp_t model(input logic [8:0] d, input bit chained);
    exp_t e;
    int   n;
    int   k;
    logic x;
    bit   pe;
    n = eff_ds(ds);
    x = 1'b0;
    e.bits = '0;
    for (int i = 0; i < n; i++) begin
      e.bits[1+i] = d[i];
      x = x ^ d[i];
    end
    k = 1 + n;
    pe = 1'b1;
    case (par)
      3'b010:  e.bits[k] = x;
      3'b011:  e.bits[k] = ~x;
      3'b100:  e.bits[k] = 1'b0;
      3'b101:  e.bits[k] = 1'b1;
      default: pe = 1'b0;
    endcase
    if (pe) k++;
    e.bits[k]   = 1'b1;
    e.nbits     = k + 1;
    e.cpb       = cpb;
    e.frame_clk = k * cpb + ((stp == 2'b00) ? 2 : (stp == 2'b01) ? 3 : 4) * cpb / 2;
    e.chained   = chained;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done        <= n_done + 1;
      last_done_cyc <= cyc;
    end
    if (rdy_prev && ready === 1'b0) n_rdy_fall <= n_rdy_fall + 1;
    rdy_prev <= (ready === 1'b1);
  end

  exp_t        mon_e;
  logic [15:0] mon_got;
  int          mon_pos, mon_st;
  bit          mon_ab;

  // Line monitor: detect a start bit, sample every bit centre, compare.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b0 && tx === 1'b0 && sb.size() > 0) begin
        mon_e   = sb.pop_front();
        mon_got = '0;
        mon_pos = 0;
        mon_ab  = 1'b0;
        mon_st  = cyc;
        if (mon_e.chained) check("b2b_spacing", 32'(mon_st - last_start), 32'(prev_clk));
        for (int k = 0; k < mon_e.nbits; k++) begin
          while (mon_pos < k * mon_e.cpb + mon_e.cpb / 2 && !mon_ab) begin
            @(negedge clk);
            mon_pos++;
            if (rst !== 1'b0) mon_ab = 1'b1;
          end
          if (mon_ab) break;
          mon_got[k] = tx;
        end
        if (!mon_ab) check("frame_bits", 32'(mon_got), 32'(mon_e.bits));
        last_start = mon_st;
        prev_clk   = mon_e.frame_clk;
      end
    end
  end

  task automatic cfg(input logic [15:0] i, input logic [3:0] d, input logic [2:0] p,
                     input logic [1:0] s);
    incr = i; ds = d; par = p; stp = s;
    cpb  = 65536 / int'(i);
  endtask

  // Offer a character (called at a negedge) and queue its expected frame on acceptance.
  task automatic send(input logic [8:0] d, input bit chained);
    int t = 0;
    valid = 1'b1;
    data  = d;
    while (ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      check("ready_wait", 32'(ready), 32'd1);
      return;
    end
    sb.push_back(model(d, chained));
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  typedef struct { logic [3:0] d; logic [2:0] p; logic [8:0] v; } ptab_t;
  ptab_t ptab[7];

  int a0, d0, r0, t, highs;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = 9'd0; brk = 1'b0;
    cfg(16'h8000, 4'd8, 3'b000, 2'b00);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, 8N1, 2 clk per bit: latency and done timing
    d0 = n_done;
    send(9'h0A5, 1'b0);
    valid = 1'b0;
    a0 = acc_cyc;
    wait_idle();
    check("lat_start", 32'(last_start - a0), 32'd2);
    check("lat_done", 32'(last_done_cyc - a0), 32'd21);
    check("done_once_a5", 32'(n_done - d0), 32'd1);

    // Parity modes and data-size clamping
    ptab[0] = '{4'd7,  3'b010, 9'h003};
    ptab[1] = '{4'd7,  3'b011, 9'h003};
    ptab[2] = '{4'd7,  3'b101, 9'h003};
    ptab[3] = '{4'd7,  3'b100, 9'h003};
    ptab[4] = '{4'd9,  3'b010, 9'h1FF};
    ptab[5] = '{4'd15, 3'b011, 9'h1B6};
    ptab[6] = '{4'd2,  3'b000, 9'h1F3};
    d0 = n_done;
    for (int i = 0; i < 7; i++) begin
      cfg(16'h8000, ptab[i].d, ptab[i].p, 2'b00);
      send(ptab[i].v, 1'b0);
      valid = 1'b0;
      wait_idle();
    end
    check("done_parity_set", 32'(n_done - d0), 32'd7);

    // Back-to-back with valid held high
    cfg(16'h8000, 4'd8, 3'b000, 2'b00);
    d0 = n_done;
    r0 = n_rdy_fall;
    send(9'h055, 1'b0);
    send(9'h00F, 1'b1);
    valid = 1'b0;
    wait_idle();
    check("b2b_done", 32'(n_done - d0), 32'd2);
    check("b2b_ready_falls", 32'(n_rdy_fall - r0), 32'd2);

    // 1.5 stop bits, 4 clk per bit, chained frame starts mid-accumulator
    cfg(16'h4000, 4'd8, 3'b000, 2'b01);
    d0 = n_done;
    send(9'h035, 1'b0);
    send(9'h0CA, 1'b1);
    valid = 1'b0;
    wait_idle();
    check("s15_done", 32'(n_done - d0), 32'd2);

    // Break for 10 bit times with a character accepted meanwhile
    cfg(16'h8000, 4'd8, 3'b000, 2'b00);
    mon_en = 1'b0;
    d0 = n_done;
    brk = 1'b1;
    repeat (3) @(negedge clk);
    send(9'h041, 1'b0);
    valid = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b0) highs++;
    end
    check("brk_line_low", 32'(highs), 32'd0);
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_no_done", 32'(n_done - d0), 32'd0);
    brk = 1'b0;
    t = 0;
    while (tx !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("brk_release", 32'(t >= 2 && t <= 3), 32'd1);
    mon_en = 1'b1;
    @(negedge clk);
    check("brk_idle_bit", 32'(tx), 32'd0);
    wait_idle();
    check("brk_frame_done", 32'(n_done - d0), 32'd1);

    // Reset in the middle of the data bits
    send(9'h000, 1'b0);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    d0 = n_done;
    @(negedge clk);
    send(9'h0C3, 1'b0);
    valid = 1'b0;
    a0 = acc_cyc;
    wait_idle();
    check("post_rst_lat", 32'(last_start - a0), 32'd2);
    check("post_rst_done", 32'(n_done - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
